pim_cmd_arbiter: RTL

- Two-requester command arbiter and sequencer in front of the PIM memory/ALU block.
- Accepts PIM commands (ALU op, write, read) from two independent requesters over valid/ready.
- Arbitrates round-robin, drives the PIM port with registered signals for exactly one execute cycle, then returns a response (read data or ack) to the owning requester.
- Holds the PIM port at no-op whenever it is idle.

---
 rtl/pim_cmd_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pim_cmd_arbiter.sv
// Two-requester round-robin command arbiter in front of the PIM block.
// Each accepted command is presented on registered pim_* outputs for exactly
// one EXEC cycle; the response is then held for the owner until consumed.
module pim_cmd_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [5:0]            req_opcode,
    input  logic [2*ADDR_W-1:0]   req_addr_a,
    input  logic [2*ADDR_W-1:0]   req_addr_b,
    input  logic [2*ADDR_W-1:0]   req_addr_result,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic [2:0]            pim_opcode,
    output logic [ADDR_W-1:0]     pim_addr_a,
    output logic [ADDR_W-1:0]     pim_addr_b,
    output logic [ADDR_W-1:0]     pim_addr_result,
    output logic [DATA_W-1:0]     pim_write_data,
    input  logic [DATA_W-1:0]     pim_result,
    output logic [CNT_W-1:0]      cmd_count
);

    localparam logic [2:0] OP_NOP     = 3'b101;
    localparam logic [2:0] OP_INVALID = 3'b110;
    localparam logic [2:0] OP_READ    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic                owner_reg;
    logic                rr_last_reg;
    logic [2:0]          orig_op_reg;
    logic [1:0]          rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                rsp_err_reg;
    logic [2:0]          pim_opcode_reg;
    logic [ADDR_W-1:0]   pim_addr_a_reg;
    logic [ADDR_W-1:0]   pim_addr_b_reg;
    logic [ADDR_W-1:0]   pim_addr_result_reg;
    logic [DATA_W-1:0]   pim_write_data_reg;
    logic [CNT_W-1:0]    cmd_count_reg;

    // Per-requester views of the packed request buses
    logic [2:0]          op_arr   [2];
    logic [ADDR_W-1:0]   addr_a_arr [2];
    logic [ADDR_W-1:0]   addr_b_arr [2];
    logic [ADDR_W-1:0]   addr_r_arr [2];
    logic [DATA_W-1:0]   wdata_arr  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_arr[gi]     = req_opcode[3*gi +: 3];
            assign addr_a_arr[gi] = req_addr_a[ADDR_W*gi +: ADDR_W];
            assign addr_b_arr[gi] = req_addr_b[ADDR_W*gi +: ADDR_W];
            assign addr_r_arr[gi] = req_addr_result[ADDR_W*gi +: ADDR_W];
            assign wdata_arr[gi]  = req_wdata[DATA_W*gi +: DATA_W];
        end
    endgenerate

    // Lone valid requester wins; on contention the one not served last wins
    logic grant;
    logic handshake;
    assign grant     = (req_valid == 2'b11) ? ~rr_last_reg : req_valid[1];
    assign handshake = (state_reg == IDLE) && (|req_valid);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> EXEC (one cycle) -> RESP until owner consumes
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready[owner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: ready only to the granted requester while idle
    always_comb begin
        req_ready = 2'b00;
        if (handshake) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Datapath: capture command, present to PIM, collect and hold response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg           <= 1'b0;
            rr_last_reg         <= 1'b1;
            orig_op_reg         <= OP_NOP;
            rsp_valid_reg       <= 2'b00;
            rsp_data_reg        <= '0;
            rsp_err_reg         <= 1'b0;
            pim_opcode_reg      <= OP_NOP;
            pim_addr_a_reg      <= '0;
            pim_addr_b_reg      <= '0;
            pim_addr_result_reg <= '0;
            pim_write_data_reg  <= '0;
            cmd_count_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        // The PIM only ever sees a legal opcode; invalid becomes nop
                        pim_opcode_reg      <= (op_arr[grant] == OP_INVALID) ? OP_NOP : op_arr[grant];
                        pim_addr_a_reg      <= addr_a_arr[grant];
                        pim_addr_b_reg      <= addr_b_arr[grant];
                        pim_addr_result_reg <= addr_r_arr[grant];
                        pim_write_data_reg  <= wdata_arr[grant];
                        orig_op_reg         <= op_arr[grant];
                        owner_reg           <= grant;
                        rr_last_reg         <= grant;
                    end
                end
                EXEC: begin
                    rsp_data_reg   <= (orig_op_reg == OP_READ) ? pim_result : '0;
                    rsp_err_reg    <= (orig_op_reg == OP_INVALID);
                    rsp_valid_reg  <= owner_reg ? 2'b10 : 2'b01;
                    pim_opcode_reg <= OP_NOP;
                    cmd_count_reg  <= cmd_count_reg + CNT_W'(1);
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= 2'b00;
                    end
                end
                default: begin
                    pim_opcode_reg <= OP_NOP;
                end
            endcase
        end
    end

    assign rsp_valid       = rsp_valid_reg;
    assign rsp_data        = rsp_data_reg;
    assign rsp_err         = rsp_err_reg;
    assign pim_opcode      = pim_opcode_reg;
    assign pim_addr_a      = pim_addr_a_reg;
    assign pim_addr_b      = pim_addr_b_reg;
    assign pim_addr_result = pim_addr_result_reg;
    assign pim_write_data  = pim_write_data_reg;
    assign cmd_count       = cmd_count_reg;

endmodule
